// File: rtl/adc_result_fifo.sv
// rtl/adc_result_fifo.sv - ADC sample FIFO with level/overflow flags and a watermark interrupt.
// Define ADC_FIFO_SIGNED_OUT_EN to return samples as two's complement instead of offset binary.
module adc_result_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clear,
    input  logic [15:0]       sample_in,
    input  logic              sample_strobe_in,
    input  logic              rd_req_in,
    output logic [15:0]       rd_data_out,
    output logic              rd_valid_out,
    output logic [ADDR_W:0]   level_out,
    output logic              empty_out,
    output logic              full_out,
    output logic              overflow_out,
    input  logic [ADDR_W:0]   threshold_in,
    output logic              irq_out
);

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

    logic [15:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_irq;
    logic [15:0]       r_rd_data;
    logic              r_rd_valid;

    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_ovf_set;
    logic [ADDR_W:0]   w_level_nxt;
    logic [15:0]       w_rd_word;

    // A read in the same cycle frees the slot a full FIFO needs for the incoming sample.
    assign w_wr_en   = sample_strobe_in & ena & ~clear & (~r_full | rd_req_in);
    assign w_rd_en   = rd_req_in & ~r_empty & ~clear;
    assign w_ovf_set = sample_strobe_in & ena & r_full & ~rd_req_in;

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr_en && !w_rd_en)
            w_level_nxt = r_level + LP_ONE;
        else if (w_rd_en && !w_wr_en)
            w_level_nxt = r_level - LP_ONE;
    end

`ifdef ADC_FIFO_SIGNED_OUT_EN
    assign w_rd_word = {~r_mem[r_rd_ptr][15], r_mem[r_rd_ptr][14:0]};
`else
    assign w_rd_word = r_mem[r_rd_ptr];
`endif

    // Sample storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
            r_rd_data  <= 16'h0000;
            r_rd_valid <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= w_rd_word;
            end
            r_rd_valid <= w_rd_en;
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == LP_DEPTH);
            if (w_ovf_set)
                r_overflow <= 1'b1;
            // Watermark compares the level seen this cycle, so irq trails level_out by one edge.
            r_irq <= (threshold_in != '0) && (r_level >= threshold_in);
        end
    end

    assign rd_data_out  = r_rd_data;
    assign rd_valid_out = r_rd_valid;
    assign level_out    = r_level;
    assign empty_out    = r_empty;
    assign full_out     = r_full;
    assign overflow_out = r_overflow;
    assign irq_out      = r_irq;

endmodule

// File: tb/tb_adc_result_fifo.sv
// tb/tb_adc_result_fifo.sv - self-checking bench for adc_result_fifo (vector table, directed corners, random vs queue model).
module tb_adc_result_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        clear;
    logic [15:0] sample_in;
    logic        sample_strobe_in;
    logic        rd_req_in;
    logic [15:0] rd_data_out;
    logic        rd_valid_out;
    logic [3:0]  level_out;
    logic        empty_out;
    logic        full_out;
    logic        overflow_out;
    logic [3:0]  threshold_in;
    logic        irq_out;

    int n_checks = 0;
    int n_errs   = 0;

    adc_result_fifo #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .sample_in(sample_in), .sample_strobe_in(sample_strobe_in),
        .rd_req_in(rd_req_in), .rd_data_out(rd_data_out),
        .rd_valid_out(rd_valid_out), .level_out(level_out),
        .empty_out(empty_out), .full_out(full_out),
        .overflow_out(overflow_out), .threshold_in(threshold_in),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of stored samples plus the expected registered outputs.
    logic [15:0] mq[$];
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ovf;
    logic        m_irq;

    function automatic logic [15:0] conv(input logic [15:0] d);
`ifdef ADC_FIFO_SIGNED_OUT_EN
        return d - 16'h8000;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
    endtask

    task automatic model_step();
        int lvl;
        bit wr, rd;
        lvl = mq.size();
        if (clear) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_irq   = 1'b0;
        end else begin
            wr = sample_strobe_in && ena && (lvl < DEPTH || rd_req_in);
            rd = rd_req_in && lvl > 0;
            m_irq = (threshold_in != 0) && (lvl >= int'(threshold_in));
            if (sample_strobe_in && ena && lvl == DEPTH && !rd_req_in)
                m_ovf = 1'b1;
            m_valid = rd;
            if (rd)
                m_data = conv(mq.pop_front());
            if (wr)
                mq.push_back(sample_in);
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".valid"}, 32'(rd_valid_out), 32'(m_valid));
        chk({tag, ".data"},  32'(rd_data_out),  32'(m_data));
        chk({tag, ".level"}, 32'(level_out),    32'(mq.size()));
        chk({tag, ".empty"}, 32'(empty_out),    32'(mq.size() == 0));
        chk({tag, ".full"},  32'(full_out),     32'(mq.size() == DEPTH));
        chk({tag, ".ovf"},   32'(overflow_out), 32'(m_ovf));
        chk({tag, ".irq"},   32'(irq_out),      32'(m_irq));
    endtask

    task automatic drive(input logic e, input logic cl, input logic st, input logic [15:0] s,
                         input logic rq, input logic [3:0] th);
        ena = e; clear = cl; sample_strobe_in = st; sample_in = s;
        rd_req_in = rq; threshold_in = th;
    endtask

    task automatic cyc(input string tag, input logic e, input logic cl, input logic st,
                       input logic [15:0] s, input logic rq, input logic [3:0] th);
        drive(e, cl, st, s, rq, th);
        @(posedge clk);
        model_step();
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic        st;
        logic [15:0] s;
        logic        rq;
        logic        exp_valid;
        logic [15:0] exp_raw;
        int          exp_level;
    } vec_t;

    vec_t vt[11];

    initial begin
        // Write three, read three, underflow, no fall-through, then the range endpoints.
        vt[0]  = '{1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, 1};
        vt[1]  = '{1'b1, 16'h4560, 1'b0, 1'b0, 16'h0000, 2};
        vt[2]  = '{1'b1, 16'h7890, 1'b0, 1'b0, 16'h0000, 3};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 2};
        vt[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h4560, 1};
        vt[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h7890, 0};
        vt[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h7890, 0};
        vt[7]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 16'h7890, 1};
        vt[8]  = '{1'b1, 16'hFFF0, 1'b0, 1'b0, 16'h7890, 2};
        vt[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 1};
        vt[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFF0, 0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(rd_valid_out), 32'd0);
        chk("rst.data",  32'(rd_data_out),  32'h0000);
        chk("rst.level", 32'(level_out),    32'd0);
        chk("rst.empty", 32'(empty_out),    32'd1);
        chk("rst.full",  32'(full_out),     32'd0);
        chk("rst.ovf",   32'(overflow_out), 32'd0);
        chk("rst.irq",   32'(irq_out),      32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, vt[i].st, vt[i].s, vt[i].rq, 4'd0);
            @(posedge clk);
            model_step();
            #1;
            chk($sformatf("vec%0d.valid", i), 32'(rd_valid_out), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d.data", i),  32'(rd_data_out),  32'(conv(vt[i].exp_raw)));
            chk($sformatf("vec%0d.level", i), 32'(level_out),    32'(vt[i].exp_level));
            chk($sformatf("vec%0d.empty", i), 32'(empty_out),    32'(vt[i].exp_level == 0));
        end

        // Nine writes into eight slots: ninth dropped, overflow sticky through the drain.
        for (int i = 0; i < 9; i++)
            cyc("ovf.wr", 1'b1, 1'b0, 1'b1, 16'h1000 + 16'(i * 16), 1'b0, 4'd0);
        chk("ovf.full", 32'(full_out), 32'd1);
        chk("ovf.flag", 32'(overflow_out), 32'd1);
        for (int i = 0; i < 8; i++) begin
            cyc("ovf.rd", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
            chk("ovf.rdval", 32'(rd_data_out), 32'(conv(16'h1000 + 16'(i * 16))));
        end
        chk("ovf.sticky", 32'(overflow_out), 32'd1);
        cyc("ovf.clr", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);
        chk("ovf.cleared", 32'(overflow_out), 32'd0);

        // Full with simultaneous strobe and read: both accepted, no overflow.
        for (int i = 0; i < 8; i++)
            cyc("frw.fill", 1'b1, 1'b0, 1'b1, 16'h2000 + 16'(i), 1'b0, 4'd0);
        cyc("frw.rw", 1'b1, 1'b0, 1'b1, 16'h2AA0, 1'b1, 4'd0);
        chk("frw.level", 32'(level_out), 32'd8);
        chk("frw.ovf", 32'(overflow_out), 32'd0);
        chk("frw.oldest", 32'(rd_data_out), 32'(conv(16'h2000)));
        for (int i = 0; i < 8; i++)
            cyc("frw.drain", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
        chk("frw.last", 32'(rd_data_out), 32'(conv(16'h2AA0)));

        // Watermark at 4, then disabled with threshold 0.
        for (int i = 0; i < 4; i++)
            cyc("irq.wr", 1'b1, 1'b0, 1'b1, 16'h3000 + 16'(i), 1'b0, 4'd4);
        chk("irq.low", 32'(irq_out), 32'd0);
        cyc("irq.idle", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd4);
        chk("irq.high", 32'(irq_out), 32'd1);
        cyc("irq.rd", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd4);
        cyc("irq.idle2", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd4);
        chk("irq.fell", 32'(irq_out), 32'd0);
        for (int i = 0; i < 6; i++)
            cyc("irq.thr0", 1'b1, 1'b0, 1'b1, 16'h3100, 1'b0, 4'd0);
        cyc("irq.clr", 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 4'd0);

        // Level 5 with overflow set, then clear against a strobe and a read.
        for (int i = 0; i < 9; i++)
            cyc("clr.wr", 1'b1, 1'b0, 1'b1, 16'h4000 + 16'(i), 1'b0, 4'd0);
        for (int i = 0; i < 3; i++)
            cyc("clr.rd", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
        chk("clr.pre_level", 32'(level_out), 32'd5);
        cyc("clr.go", 1'b1, 1'b1, 1'b1, 16'h4F00, 1'b1, 4'd0);
        chk("clr.level", 32'(level_out), 32'd0);
        chk("clr.ovf", 32'(overflow_out), 32'd0);
        chk("clr.valid", 32'(rd_valid_out), 32'd0);
        chk("clr.empty", 32'(empty_out), 32'd1);

        // Disabled capture ignores strobes.
        cyc("ena.off", 1'b0, 1'b0, 1'b1, 16'h5550, 1'b0, 4'd0);
        chk("ena.level", 32'(level_out), 32'd0);

        // Reset mid-stream empties immediately; first write afterwards reads back.
        cyc("mrst.wr", 1'b1, 1'b0, 1'b1, 16'h6000, 1'b0, 4'd0);
        cyc("mrst.wr", 1'b1, 1'b0, 1'b1, 16'h6010, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst.level", 32'(level_out), 32'd0);
        chk("mrst.empty", 32'(empty_out), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("mrst.first", 1'b1, 1'b0, 1'b1, 16'h6ABC, 1'b0, 4'd0);
        cyc("mrst.rd", 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd0);
        chk("mrst.data", 32'(rd_data_out), 32'(conv(16'h6ABC)));

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++)
            cyc("rnd", 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 40) == 0),
                1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 99) < 45),
                4'($urandom_range(0, 8)));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_result_fifo.md
ADC_RESULT_FIFO -- requirements
Module: adc_result_fifo

Interface
REQ-001 Parameter DEPTH, default 8, meaning FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter ADDR_W, default 3, meaning log2(DEPTH); SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ena  input  1  capture enable; strobes while low SHALL be ignored.
REQ-006 clear  input  1  synchronous flush of FIFO contents and flags.
REQ-007 sample_in  input  16  conversion result, offset binary (16'h0000 = -VCC, 16'hFFF0 = +VCC).
REQ-008 sample_strobe_in  input  1  one-cycle pulse marking sample_in valid.
REQ-009 rd_req_in  input  1  host pop request, one entry per cycle high.
REQ-010 rd_data_out  output  16  popped sample.
REQ-011 rd_valid_out  output  1  one-cycle pulse qualifying rd_data_out.
REQ-012 level_out  output  ADDR_W+1  current entry count, 0..DEPTH.
REQ-013 empty_out / full_out  output  1 each  level_out==0 / level_out==DEPTH.
REQ-014 overflow_out  output  1  sticky: a sample was dropped.
REQ-015 threshold_in  input  ADDR_W+1  watermark for irq_out.
REQ-016 irq_out  output  1  registered watermark interrupt.

Function
REQ-017 Write: sample_strobe_in & ena & ~clear & (~full_out | rd_req_in) SHALL store sample_in at the write pointer and advance it, wrapping DEPTH-1 -> 0.
REQ-018 Overflow: sample_strobe_in & ena & full_out & ~rd_req_in SHALL discard sample_in, keep contents unchanged, set overflow_out next cycle.
REQ-019 Read: rd_req_in & ~empty_out & ~clear SHALL present the oldest entry on rd_data_out with rd_valid_out=1 exactly one cycle later (latency 1), and advance the read pointer with wrap.
REQ-020 Underflow: rd_req_in while empty_out SHALL give rd_valid_out=0 next cycle, rd_data_out held, no flag set; a same-cycle write to an empty FIFO SHALL NOT fall through.
REQ-021 Simultaneous accepted read and write SHALL leave level_out unchanged; full + read + write SHALL accept both with no overflow.
REQ-022 rd_data_out SHALL hold its last value whenever rd_valid_out=0.
REQ-023 level_out, empty_out, full_out SHALL be registered and reflect the cycle's operations on the next edge.
REQ-024 irq_out SHALL be 1 in the cycle after (threshold_in != 0) & (level >= threshold_in), else 0.
REQ-025 clear SHALL, on the next edge, zero both pointers, level_out, overflow_out and irq_out, take priority over a same-cycle read and write, and produce rd_valid_out=0.
REQ-026 Storage contents SHALL NOT require reset; only pointers and flags are reset.

Reset
REQ-027 While rst_n=0: rd_data_out=16'h0000, rd_valid_out=0, level_out=0, empty_out=1, full_out=0, overflow_out=0, irq_out=0, pointers=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries immediately; first strobe after release SHALL be stored at entry 0.

Configuration
REQ-029 Macro ADC_FIFO_SIGNED_OUT_EN: when defined, rd_data_out SHALL be two's complement (sample MSB inverted on read, 16'h8000 -> 16'h0000); when undefined, rd_data_out SHALL be the stored offset-binary value unchanged.
REQ-030 The macro SHALL affect only the rd_data_out data path; flags, latency and reset values SHALL be identical in both builds (reset rd_data_out=16'h0000 in both).

Verification
REQ-031 Write 3 samples 16'h1230,16'h4560,16'h7890, then 3 reads -> rd_data_out in same order, each rd_valid_out one cycle after rd_req_in, level_out 3->0, empty_out=1.
REQ-032 Write 9 samples with DEPTH=8, no reads -> full_out=1, overflow_out=1, 9th sample absent; 8 reads return samples 1..8; overflow_out stays 1 until clear.
REQ-033 FIFO full, strobe and rd_req_in same cycle -> level_out stays 8, overflow_out=0, oldest returned, new sample read last.
REQ-034 threshold_in=4, write 4 samples -> irq_out rises cycle after 4th write; one read -> irq_out falls; threshold_in=0 -> irq_out never 1.
REQ-035 level_out=5 with overflow_out=1, assert clear with concurrent strobe and rd_req_in -> next cycle level_out=0, overflow_out=0, rd_valid_out=0, empty_out=1.
REQ-036 Write 16'h8000 and 16'hFFF0 then read -> with ADC_FIFO_SIGNED_OUT_EN 16'h0000, 16'h7FF0; without 16'h8000, 16'hFFF0; rst_n pulse mid-stream -> level_out=0 immediately.
